cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
//  Minimal 8-bit accumulator CPU for the board top level: reads 8 switches, drives 8 LEDs.
//  - Program: internal constant ROM.
//  - Timing: single-cycle; one instruction fetched and executed per rising clk.
//  - Role: the complete datapath plus control of the design; no external memory bus.
// PARAMETERS
//  PC_W  8  program-counter width; ROM depth = 2**PC_W words; PC wraps (2**PC_W-1 -> 0).
// PORTS
//  clk      in   1  single system clock; all state changes on rising edge.
//  clr      in   1  synchronous, active-high reset.
//  swiches  in   8  switch inputs, sampled by IN/ADS; no synchronizer inside the block.
//  leds     out  8  registered LED output, written only by OUT.
// BEHAVIOUR
//  Reset (clr=1 at posedge): pc=0, A=0, Z=0, C=0, leds=8'h00.
//  - Reset dominates any instruction in that cycle.
//  - Held clr keeps all state at reset values.
//  - First instruction executes at the first posedge with clr=0.
//  Instruction word: 12 bits = {op[11:8], imm[7:0]}.
//  Fetch is combinational: instr = ROM[pc]; state update at the same posedge.
//  Opcodes (Z = (result==0) for ALU/load ops; C unchanged unless stated):
//   0 NOP   no effect.
//   1 LDI   A=imm.
//   2 IN    A=swiches.
//   3 OUT   leds<=A; flags unchanged.
//   4 ADD   {C,A}=A+imm (9-bit sum).
//   5 SUB   A=A-imm; C=1 on borrow (A<imm).
//   6 AND   A=A&imm; C=0.
//   7 OR    A=A|imm; C=0.
//   8 XOR   A=A^imm; C=0.
//   9 JMP   pc=imm[PC_W-1:0].
//   A JZ    pc=imm if Z, else pc+1.
//   B JC    pc=imm if C, else pc+1.
//   C ADS   {C,A}=A+swiches.
//   D-F     reserved: execute as NOP.
//  Program counter:
//  - Non-jump instructions: pc=pc+1 mod 2**PC_W.
//  - Jump targets: truncate imm to PC_W bits; if PC_W>8, zero-extend imm.
//  Flags:
//  - Z, C are registered and reflect the last instruction that wrote them.
//  - Conditional jumps test flags as they were before the current cycle.
//  Arithmetic: unsigned 8-bit, wrap-around; 0xFF+0x01 -> A=0x00, Z=1, C=1.
//  leds holds its value between OUT instructions; no combinational path from swiches to leds.
//  Default ROM contents (all other words NOP = 12'h000):
//   0: IN
//   1: OUT
//   2: ADD 0x01
//   3: OUT
//   4: JMP 0x00
// STRUCTURE
//  - cpu_pkg: opcode localparams (OP_NOP..OP_ADS), INSTR_W=12, DATA_W=8.
//  - cpu_alu sub-module: combinational; inputs op, a, b; outputs result[7:0], z, c, writes_a,
//    writes_c.
//  - cpu top: pc/A/flag/leds registers, ROM (case-based function), next-pc logic.
// TESTING
//  1) clr=1 for 3 clks, swiches=8'h48 -> pc=0, A=0, leds=8'h00 throughout.
//  2) clr=0, swiches=8'h48, default ROM ->
//     - leds=8'h48 after 2nd posedge;
//     - leds=8'h49 after 4th;
//     - pc returns to 0 after 5th; pattern repeats.
//  3) Assert clr mid-program (pc=3) -> next posedge pc=0, A=0, leds=8'h00.
//  4) ROM: LDI 0xFF; ADD 0x01; JC 0x05 -> A=0x00, Z=1, C=1, pc=5 after 3 posedges.
//  5) ROM: LDI 0x10; SUB 0x20; OUT -> A=8'hF0, C=1, leds=8'hF0; SUB 0x10 on 0x10 -> Z=1.
//  6) Reserved op 0xD and PC wrap with PC_W=4:
//     - reserved op: no state change except pc+1;
//     - pc 15 -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Purpose : shared ISA constants for the 8-bit accumulator CPU.
// Latency : n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;
    localparam int INSTR_W  = 12;
    localparam int DATA_W   = 8;
    localparam int ROM_PROG = 16;   // words loadable through the PROG parameter

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_IN  = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_ADS = 4'hC;
endpackage

// File: rtl/cpu_alu.sv
// Purpose : combinational ALU; computes the new accumulator value and flags for one opcode.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op_i opcode, a_i accumulator, b_i operand (imm or switches);
//        result_o new A, z_o/c_o new flags, writes_a_o (A and Z update), writes_c_o (C update).
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o,
    output logic              writes_a_o,
    output logic              writes_c_o
);
    logic [DATA_W:0] sum;

    always_comb begin
        result_o   = a_i;
        c_o        = 1'b0;
        writes_a_o = 1'b0;
        writes_c_o = 1'b0;
        sum        = {1'b0, a_i} + {1'b0, b_i};
        case (op_i)
            OP_LDI, OP_IN: begin
                result_o   = b_i;
                writes_a_o = 1'b1;
            end
            OP_ADD, OP_ADS: begin
                result_o   = sum[DATA_W-1:0];
                c_o        = sum[DATA_W];
                writes_a_o = 1'b1;
                writes_c_o = 1'b1;
            end
            OP_SUB: begin
                result_o   = a_i - b_i;
                c_o        = (a_i < b_i);   // borrow
                writes_a_o = 1'b1;
                writes_c_o = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                result_o   = (op_i == OP_AND) ? (a_i & b_i) :
                             (op_i == OP_OR)  ? (a_i | b_i) : (a_i ^ b_i);
                writes_a_o = 1'b1;
                writes_c_o = 1'b1;          // logic ops clear C
            end
            default: ;
        endcase
        z_o = (result_o == '0);
    end
endmodule

// File: rtl/cpu.sv
// Purpose : single-cycle 8-bit accumulator CPU with internal constant ROM, switches in, LEDs out.
// Latency : one instruction per rising clk; leds registered (updated at the OUT edge).
// Backpressure: none; executes continuously while clr is low.
// Ports: clk clock, clr sync active-high reset, swiches switch inputs, leds registered LED output.
// PROG holds ROM words 0..15 (word i at [i*12 +: 12]); every other address reads NOP. PC_W >= 4.
module cpu
    import cpu_pkg::*;
#(
    parameter int                          PC_W = 8,
    parameter logic [ROM_PROG*INSTR_W-1:0] PROG = {132'h0, 12'h900, 12'h300,
                                                   12'h401, 12'h300, 12'h200}
)(
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] swiches,
    output logic [DATA_W-1:0] leds
);
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]  a_q, a_d, leds_q, leds_d;
    logic               z_q, z_d, c_q, c_d;

    logic [INSTR_W-1:0] prog_mem [ROM_PROG];
    logic [INSTR_W-1:0] instr;
    logic [3:0]         op;
    logic [DATA_W-1:0]  imm, alu_b, alu_res;
    logic               alu_z, alu_c, wr_a, wr_c;
    logic [PC_W-1:0]    target;

    always_comb begin
        for (int i = 0; i < ROM_PROG; i++) begin
            prog_mem[i] = PROG[i*INSTR_W +: INSTR_W];
        end
    end

    // Combinational fetch; addresses beyond the loadable window read NOP.
    always_comb begin
        instr = '0;
        if ((pc_q >> 4) == '0) begin
            instr = prog_mem[pc_q[3:0]];
        end
    end

    assign op     = instr[11:8];
    assign imm    = instr[7:0];
    assign alu_b  = (op == OP_IN || op == OP_ADS) ? swiches : imm;
    assign target = PC_W'(imm);     // truncates or zero-extends to PC_W

    cpu_alu u_alu (
        .op_i       (op),
        .a_i        (a_q),
        .b_i        (alu_b),
        .result_o   (alu_res),
        .z_o        (alu_z),
        .c_o        (alu_c),
        .writes_a_o (wr_a),
        .writes_c_o (wr_c)
    );

    always_comb begin
        pc_d   = pc_q + PC_W'(1);
        a_d    = a_q;
        z_d    = z_q;
        c_d    = c_q;
        leds_d = leds_q;
        if (wr_a) begin
            a_d = alu_res;
            z_d = alu_z;
        end
        if (wr_c) begin
            c_d = alu_c;
        end
        // Conditional jumps look at the registered flags, i.e. before this instruction.
        case (op)
            OP_OUT: leds_d = a_q;
            OP_JMP: pc_d = target;
            OP_JZ:  if (z_q) pc_d = target;
            OP_JC:  if (c_q) pc_d = target;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q   <= '0;
            a_q    <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            leds_q <= '0;
        end else begin
            pc_q   <= pc_d;
            a_q    <= a_d;
            z_q    <= z_d;
            c_q    <= c_d;
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;
endmodule

// File: tb/tb_cpu.sv
// Purpose : self-checking bench; three CPU instances run against an instruction-level model.
// Latency : checks 1 time unit after every rising edge.
// Backpressure: n/a.
module tb_cpu;
    localparam logic [191:0] P0 = {132'h0, 12'h900, 12'h300, 12'h401, 12'h300, 12'h200};
    localparam logic [191:0] P1 = {12'hE00, 12'h63C, 12'hC00, 12'h781, 12'hA0C, 12'h510,
                                   12'h110, 12'hD00, 12'h300, 12'h520, 12'h110, 12'h000,
                                   12'h000, 12'hB05, 12'h401, 12'h1FF};
    localparam logic [191:0] P2 = {12'h000, 12'h000, 12'h000, 12'h900, 12'h300, 12'hA00,
                                   12'h537, 12'h900, 12'h300, 12'hB09, 12'hC00, 12'h300,
                                   12'h63C, 12'h781, 12'h8A5, 12'h200};

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] swiches;
    logic [7:0] leds0, leds1, leds2;

    int checks = 0;
    int errors = 0;

    int         pcw   [3] = '{8, 4, 8};
    logic [11:0] prog [3][16];
    int m_pc[3], m_a[3], m_z[3], m_c[3], m_led[3];

    always #5 clk = ~clk;

    cpu u_dut0 (.clk(clk), .clr(clr), .swiches(swiches), .leds(leds0));
    cpu #(.PC_W(4), .PROG(P1)) u_dut1 (.clk(clk), .clr(clr), .swiches(swiches), .leds(leds1));
    cpu #(.PC_W(8), .PROG(P2)) u_dut2 (.clk(clk), .clr(clr), .swiches(swiches), .leds(leds2));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-level reference: interprets the bench's own copy of each program.
    task automatic model_step(input int k, input bit rst, input int sw);
        logic [11:0] w;
        int op, imm, s, npc, mask;
        if (rst) begin
            m_pc[k] = 0; m_a[k] = 0; m_z[k] = 0; m_c[k] = 0; m_led[k] = 0;
            return;
        end
        mask = (1 << pcw[k]) - 1;
        w    = (m_pc[k] < 16) ? prog[k][m_pc[k]] : 12'h000;
        op   = int'(w[11:8]);
        imm  = int'(w[7:0]);
        npc  = (m_pc[k] + 1) & mask;
        case (op)
            1:  m_a[k] = imm;
            2:  m_a[k] = sw;
            3:  m_led[k] = m_a[k];
            4, 12: begin
                s = m_a[k] + ((op == 4) ? imm : sw);
                m_c[k] = (s > 255) ? 1 : 0;
                m_a[k] = s % 256;
            end
            5: begin
                m_c[k] = (m_a[k] < imm) ? 1 : 0;
                m_a[k] = (m_a[k] - imm + 256) % 256;
            end
            6:  begin m_a[k] = m_a[k] & imm; m_c[k] = 0; end
            7:  begin m_a[k] = m_a[k] | imm; m_c[k] = 0; end
            8:  begin m_a[k] = m_a[k] ^ imm; m_c[k] = 0; end
            9:  npc = imm & mask;
            10: if (m_z[k] != 0) npc = imm & mask;
            11: if (m_c[k] != 0) npc = imm & mask;
            default: ;
        endcase
        if (op inside {1, 2, 4, 5, 6, 7, 8, 12}) m_z[k] = (m_a[k] == 0) ? 1 : 0;
        m_pc[k] = npc;
    endtask

    task automatic cmp_inst(input int k, input int pc, input int a, input int z,
                            input int c, input int led);
        chk($sformatf("d%0d_pc", k), pc, m_pc[k]);
        chk($sformatf("d%0d_a", k), a, m_a[k]);
        chk($sformatf("d%0d_z", k), z, m_z[k]);
        chk($sformatf("d%0d_c", k), c, m_c[k]);
        chk($sformatf("d%0d_leds", k), led, m_led[k]);
    endtask

    task automatic cycle(input bit clr_v, input logic [7:0] sw_v);
        clr     = clr_v;
        swiches = sw_v;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, clr_v, int'(sw_v));
        #1;
        cmp_inst(0, int'(u_dut0.pc_q), int'(u_dut0.a_q), int'(u_dut0.z_q), int'(u_dut0.c_q), int'(leds0));
        cmp_inst(1, int'(u_dut1.pc_q), int'(u_dut1.a_q), int'(u_dut1.z_q), int'(u_dut1.c_q), int'(leds1));
        cmp_inst(2, int'(u_dut2.pc_q), int'(u_dut2.a_q), int'(u_dut2.z_q), int'(u_dut2.c_q), int'(leds2));
    endtask

    initial begin
        logic [191:0] p;
        int n;
        for (int i = 0; i < 16; i++) begin
            p = P0; prog[0][i] = p[i*12 +: 12];
            p = P1; prog[1][i] = p[i*12 +: 12];
            p = P2; prog[2][i] = p[i*12 +: 12];
        end
        clr = 1'b1;
        swiches = 8'h48;

        // Held reset with switches active.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h48);
            chk("rst_pc", int'(u_dut0.pc_q), 0);
            chk("rst_a", int'(u_dut0.a_q), 0);
            chk("rst_leds", int'(leds0), 8'h00);
        end

        // Default program plus the directed programs from reset.
        for (n = 1; n <= 16; n++) begin
            cycle(1'b0, 8'h48);
            if (n == 2)  chk("def_leds_2", int'(leds0), 8'h48);
            if (n == 4)  chk("def_leds_4", int'(leds0), 8'h49);
            if (n == 5)  chk("def_pc_5", int'(u_dut0.pc_q), 0);
            if (n == 7)  chk("def_leds_7", int'(leds0), 8'h48);
            if (n == 3) begin
                chk("jc_pc", int'(u_dut1.pc_q), 5);
                chk("jc_a", int'(u_dut1.a_q), 0);
                chk("jc_z", int'(u_dut1.z_q), 1);
                chk("jc_c", int'(u_dut1.c_q), 1);
            end
            if (n == 6) begin
                chk("sub_a", int'(u_dut1.a_q), 8'hF0);
                chk("sub_c", int'(u_dut1.c_q), 1);
                chk("sub_leds", int'(leds1), 8'hF0);
            end
            if (n == 7) begin
                chk("rsv_pc", int'(u_dut1.pc_q), 9);
                chk("rsv_a", int'(u_dut1.a_q), 8'hF0);
                chk("rsv_c", int'(u_dut1.c_q), 1);
                chk("rsv_z", int'(u_dut1.z_q), 0);
            end
            if (n == 9)  chk("subz_z", int'(u_dut1.z_q), 1);
            if (n == 14) chk("wrap_pc", int'(u_dut1.pc_q), 0);
        end

        // Reset asserted mid-program at pc=3.
        n = 0;
        while (m_pc[0] != 3 && n < 10) begin
            cycle(1'b0, 8'($urandom));
            n++;
        end
        chk("reach_pc3", m_pc[0], 3);
        cycle(1'b1, 8'($urandom));
        chk("mid_rst_pc", int'(u_dut0.pc_q), 0);
        chk("mid_rst_a", int'(u_dut0.a_q), 0);
        chk("mid_rst_leds", int'(leds0), 0);

        // Random switches with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
